// File: rtl/fpga_pkg.sv
// Shared encodings for the AXI read scheduler: requester source tags and AR-stage states.
package fpga_pkg;

    localparam logic [1:0] SRC_ICACHE = 2'd0;
    localparam logic [1:0] SRC_DMISS  = 2'd1;
    localparam logic [1:0] SRC_DUC    = 2'd2;
    localparam logic [1:0] SRC_BAD    = 2'd3;

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_BUSY = 1'b1
    } ar_state_e;

    function automatic logic [1:0] onehot3_idx(input logic [2:0] oh);
        return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter; search starts just after the last granted requester.
module rr_arb3
    import fpga_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] eligible,
    input  logic       advance,
    output logic [2:0] grant
);

    logic [1:0] last_q;
    logic [1:0] idx;

    always_comb begin
        grant = '0;
        idx   = last_q;
        for (int k = 0; k < 3; k++) begin
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (grant == '0 && eligible[idx]) grant[idx] = 1'b1;
        end
    end

    // Reset to 2 so requester 0 is searched first.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                   last_q <= 2'd2;
        else if (advance && |grant)    last_q <= onehot3_idx(grant);
    end

endmodule

// File: rtl/axi_read_sched.sv
// Arbitrates three read requesters onto one AXI AR channel and steers R beats back by source tag.
module axi_read_sched
    import fpga_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 128,
    parameter int ID_WIDTH   = 4,
    parameter int MAX_OUTST  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [2:0]              req_valid_i,
    output logic [2:0]              req_ready_o,
    input  logic [3*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [23:0]             req_len_i,
    input  logic [3*ID_WIDTH-1:0]   req_id_i,
    output logic                    ar_valid_o,
    input  logic                    ar_ready_i,
    output logic [ADDR_WIDTH-1:0]   ar_addr_o,
    output logic [7:0]              ar_len_o,
    output logic [ID_WIDTH+1:0]     ar_id_o,
    input  logic                    r_valid_i,
    output logic                    r_ready_o,
    input  logic [DATA_WIDTH-1:0]   r_data_i,
    input  logic [ID_WIDTH+1:0]     r_id_i,
    input  logic                    r_last_i,
    output logic [2:0]              resp_valid_o,
    input  logic [2:0]              resp_ready_i,
    output logic [DATA_WIDTH-1:0]   resp_data_o,
    output logic [ID_WIDTH-1:0]     resp_id_o,
    output logic                    resp_last_o,
    output logic                    err_bad_id_o
);

    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    ar_state_e        state;
    logic [2:0]       eligible;
    logic [2:0]       grant;
    logic [1:0]       gidx;
    logic [1:0]       r_src;
    logic [1:0]       ar_src;
    logic [CNT_W-1:0] cnt [3];
    logic [3:0]       rdy_ext;
    logic [3:0]       vld_ext;

    assign gidx   = onehot3_idx(grant);
    assign r_src  = r_id_i[ID_WIDTH+1:ID_WIDTH];
    assign ar_src = ar_id_o[ID_WIDTH+1:ID_WIDTH];

    rr_arb3 u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .eligible (eligible),
        .advance  (state == AR_IDLE),
        .grant    (grant)
    );

    // Ready is only offered while the AR register is free, and never under reset.
    assign req_ready_o = (rst_ni && state == AR_IDLE) ? grant : 3'b000;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= AR_IDLE;
            ar_valid_o <= 1'b0;
            ar_addr_o  <= '0;
            ar_len_o   <= '0;
            ar_id_o    <= '0;
        end else begin
            case (state)
                AR_IDLE: if (|grant) begin
                    state      <= AR_BUSY;
                    ar_valid_o <= 1'b1;
                    ar_addr_o  <= req_addr_i[int'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
                    ar_len_o   <= req_len_i[int'(gidx)*8 +: 8];
                    ar_id_o    <= {gidx, req_id_i[int'(gidx)*ID_WIDTH +: ID_WIDTH]};
                end
                AR_BUSY: if (ar_ready_i) begin
                    state      <= AR_IDLE;
                    ar_valid_o <= 1'b0;
                end
                default: state <= AR_IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_cnt
        logic inc, dec;
        assign inc = ar_valid_o && ar_ready_i && ar_src == 2'(i);
        assign dec = r_valid_i && r_ready_o && r_last_i && r_src == 2'(i);
        assign eligible[i] = req_valid_i[i] && (cnt[i] < CNT_W'(MAX_OUTST));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)
                cnt[i] <= '0;
            else if (inc && !dec && cnt[i] != CNT_W'(MAX_OUTST))
                cnt[i] <= cnt[i] + 1'b1;
            else if (dec && !inc && cnt[i] != '0)
                cnt[i] <= cnt[i] - 1'b1;
        end
    end

    // Tag 3 maps to an always-ready, never-valid slot so bad beats drain silently.
    assign rdy_ext      = {1'b1, resp_ready_i};
    assign vld_ext      = r_valid_i ? (4'b0001 << r_src) : 4'b0000;
    assign r_ready_o    = rdy_ext[r_src];
    assign resp_valid_o = vld_ext[2:0];
    assign resp_data_o  = r_data_i;
    assign resp_id_o    = r_id_i[ID_WIDTH-1:0];
    assign resp_last_o  = r_last_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                          err_bad_id_o <= 1'b0;
        else if (r_valid_i && r_src == SRC_BAD) err_bad_id_o <= 1'b1;
    end

endmodule

// File: tb/tb_axi_read_sched.sv
// Randomized bench for axi_read_sched against a transaction-level reference model.
module tb_axi_read_sched;

    localparam int AW  = 64;
    localparam int DW  = 128;
    localparam int IW  = 4;
    localparam int MAX = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [2:0]        req_valid = '0;
    logic [2:0]        req_ready;
    logic [3*AW-1:0]   req_addr = '0;
    logic [23:0]       req_len = '0;
    logic [3*IW-1:0]   req_id = '0;
    logic              ar_valid;
    logic              ar_ready = 1'b0;
    logic [AW-1:0]     ar_addr;
    logic [7:0]        ar_len;
    logic [IW+1:0]     ar_id;
    logic              r_valid = 1'b0;
    logic              r_ready;
    logic [DW-1:0]     r_data = '0;
    logic [IW+1:0]     r_id = '0;
    logic              r_last = 1'b0;
    logic [2:0]        resp_valid;
    logic [2:0]        resp_ready = '0;
    logic [DW-1:0]     resp_data;
    logic [IW-1:0]     resp_id;
    logic              resp_last;
    logic              err_bad_id;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: outstanding bursts, last winner, pending AR contents, sticky error.
    int          m_cnt [3];
    int          m_last;
    bit          m_pend;
    bit          m_inrst;
    bit          m_err;
    logic [63:0] m_addr;
    logic [7:0]  m_len;
    logic [5:0]  m_id;

    always #5 clk = ~clk;

    axi_read_sched #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .ID_WIDTH   (IW),
        .MAX_OUTST  (MAX)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_len_i    (req_len),
        .req_id_i     (req_id),
        .ar_valid_o   (ar_valid),
        .ar_ready_i   (ar_ready),
        .ar_addr_o    (ar_addr),
        .ar_len_o     (ar_len),
        .ar_id_o      (ar_id),
        .r_valid_i    (r_valid),
        .r_ready_o    (r_ready),
        .r_data_i     (r_data),
        .r_id_i       (r_id),
        .r_last_i     (r_last),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_id_o    (resp_id),
        .resp_last_o  (resp_last),
        .err_bad_id_o (err_bad_id)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_last = 2;
        m_pend = 0;
        m_err  = 0;
        m_addr = '0;
        m_len  = '0;
        m_id   = '0;
    endtask

    // Called at a falling edge with inputs applied; checks, then advances the model past the next rising edge.
    task automatic step();
        int         win;
        int         s;
        int         inc_s;
        int         dec_s;
        logic [2:0] exp_rv;
        logic       exp_rr;
        #1;
        win = -1;
        if (!m_inrst && !m_pend)
            for (int k = 1; k <= 3; k++) begin
                int i;
                i = (m_last + k) % 3;
                if (win < 0 && req_valid[i] && m_cnt[i] < MAX) win = i;
            end
        chk("req_ready", {125'd0, req_ready}, (win >= 0) ? (128'd1 << win) : 128'd0);
        chk("ar_valid", {127'd0, ar_valid}, {127'd0, m_pend});
        if (m_pend || m_inrst) begin
            chk("ar_addr", {64'd0, ar_addr}, {64'd0, m_addr});
            chk("ar_len", {120'd0, ar_len}, {120'd0, m_len});
            chk("ar_id", {122'd0, ar_id}, {122'd0, m_id});
        end
        s      = int'(r_id[5:4]);
        exp_rv = (r_valid && s != 3) ? (3'b001 << s) : 3'b000;
        exp_rr = (s == 3) ? 1'b1 : resp_ready[s];
        chk("resp_valid", {125'd0, resp_valid}, {125'd0, exp_rv});
        chk("r_ready", {127'd0, r_ready}, {127'd0, exp_rr});
        if (exp_rv != 3'b000) begin
            chk("resp_data", resp_data, r_data);
            chk("resp_id", {124'd0, resp_id}, {124'd0, r_id[3:0]});
            chk("resp_last", {127'd0, resp_last}, {127'd0, r_last});
        end
        chk("err_bad_id", {127'd0, err_bad_id}, {127'd0, m_err});

        if (!m_inrst) begin
            inc_s = (m_pend && ar_ready) ? int'(m_id[5:4]) : -1;
            dec_s = (r_valid && exp_rr && r_last && s != 3) ? s : -1;
            for (int i = 0; i < 3; i++) begin
                if (inc_s == i && dec_s == i) ;
                else if (inc_s == i && m_cnt[i] < MAX) m_cnt[i]++;
                else if (dec_s == i && m_cnt[i] > 0)   m_cnt[i]--;
            end
            if (r_valid && s == 3) m_err = 1;
            if (win >= 0) begin
                m_pend = 1;
                m_last = win;
                m_addr = req_addr[win*AW +: AW];
                m_len  = req_len[win*8 +: 8];
                m_id   = {2'(win), req_id[win*IW +: IW]};
            end else if (m_pend && ar_ready) begin
                m_pend = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        m_inrst = 1;
        model_clear();
        step();
        rst_n   = 1'b1;
        m_inrst = 0;
    endtask

    task automatic rand_in(input bit all_req, input int ar_pct, input bit r_on);
        req_valid = all_req ? 3'b111 : 3'($urandom_range(0, 7));
        for (int i = 0; i < 3; i++) begin
            req_addr[i*AW +: AW] = {$urandom, $urandom};
            req_len[i*8 +: 8]    = 8'($urandom);
            req_id[i*IW +: IW]   = 4'($urandom);
        end
        ar_ready   = ($urandom_range(0, 99) < ar_pct);
        r_valid    = r_on && ($urandom_range(0, 2) == 0);
        r_id       = {($urandom_range(0, 29) == 0) ? 2'd3 : 2'($urandom_range(0, 2)), 4'($urandom)};
        r_last     = 1'($urandom);
        resp_ready = 3'($urandom_range(0, 7));
        r_data     = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        m_inrst = 1;
        model_clear();
        @(negedge clk);
        do_reset();

        // Single icache refill: ready now, AR one cycle later.
        req_valid = 3'b001;
        req_addr[AW-1:0] = 64'h0000_0000_8000_0040;
        req_len[7:0] = 8'd1;
        req_id[IW-1:0] = 4'h8;
        step();
        chk("ar_id_first", {122'd0, ar_id}, 128'h08);
        chk("ar_addr_first", {64'd0, ar_addr}, 128'h8000_0040);
        req_valid = 3'b000;
        ar_ready  = 1'b1;
        step();
        step();

        // All requesters busy, no R: round-robin then outstanding limit stalls everyone.
        for (int c = 0; c < 20; c++) begin
            rand_in(1, 100, 0);
            step();
        end
        // One rlast to icache reopens it.
        rand_in(1, 100, 0);
        r_valid = 1'b1; r_id = 6'h00; r_last = 1'b1; resp_ready = 3'b001;
        step();
        for (int c = 0; c < 4; c++) begin
            rand_in(1, 100, 0);
            step();
        end

        // Source 1 ready, source 2 not; then bad tag.
        rand_in(0, 0, 0);
        r_valid = 1'b1; r_id = 6'h13; resp_ready = 3'b010;
        step();
        r_id = 6'h25;
        step();
        resp_ready = 3'b100;
        step();
        r_id = 6'h30;
        step();
        r_valid = 1'b0;
        step();

        // Long AR backpressure, then mixed traffic.
        for (int c = 0; c < 300; c++) begin
            rand_in(0, (c < 100) ? 10 : 60, 1);
            step();
        end
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            rand_in($urandom_range(0, 3) == 0, $urandom_range(0, 100), 1);
            step();
        end
        do_reset();
        for (int c = 0; c < 300; c++) begin
            rand_in(0, 70, 1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
